csr_timer: RTL

//  Constant timer unit behind the core's CSR file: holds TID, TCFG and TVAL, decrements

---
 rtl/csr_timer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/csr_timer.sv
// -----------------------------------------------------------------------------
// csr_timer
//   Constant timer unit that sits behind the core's CSR file. It holds three
//   architectural registers: TID (timer id), TCFG (enable / periodic / initial
//   value) and TVAL (the running count). While enabled, TVAL counts down once
//   per clock. When an enabled timer reaches zero it raises the timer
//   interrupt level (timer_int). A TICLR write acknowledges that interrupt.
//
// Parameters
//   TIMER_W    counter width (8..32); CSR bits at and above TIMER_W read as 0
//   TID_RESET  value loaded into TID by reset
//
// Ports
//   clk          in   1   core clock
//   reset        in   1   synchronous reset, active-high
//   csr_wr_en    in   1   CSR write strobe, one cycle per write
//   csr_wr_addr  in   14  CSR write address
//   csr_wr_data  in   32  CSR write data, already merged with the write mask
//   csr_rd_addr  in   14  CSR read address
//   csr_rd_data  out  32  combinational read data; 0 when csr_rd_hit is 0
//   csr_rd_hit   out  1   csr_rd_addr selects TID, TCFG, TVAL or TICLR
//   timer_int    out  1   timer interrupt level, held until cleared via TICLR
// -----------------------------------------------------------------------------
module csr_timer #(
  parameter int unsigned TIMER_W   = 32,
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_wr_en,
  input  logic [13:0] csr_wr_addr,
  input  logic [31:0] csr_wr_data,
  input  logic [13:0] csr_rd_addr,
  output logic [31:0] csr_rd_data,
  output logic        csr_rd_hit,
  output logic        timer_int
);

  // CSR addresses handled by this block.
  localparam logic [13:0] ADDR_TID   = 14'h040;
  localparam logic [13:0] ADDR_TCFG  = 14'h041;
  localparam logic [13:0] ADDR_TVAL  = 14'h042;
  localparam logic [13:0] ADDR_TICLR = 14'h044;

  localparam logic [TIMER_W-1:0] CNT_ONE  = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] CNT_ONES = '1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]        tid_q,  tid_d;
  logic [TIMER_W-1:0] tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] tval_q, tval_d;
  logic               ti_q,   ti_d;

  // ---------------------------------------------------------------------------
  // Decoded write strobes
  // ---------------------------------------------------------------------------
  logic wr_tid;
  logic wr_tcfg;
  logic wr_ticlr;

  assign wr_tid   = csr_wr_en && (csr_wr_addr == ADDR_TID);
  assign wr_tcfg  = csr_wr_en && (csr_wr_addr == ADDR_TCFG);
  assign wr_ticlr = csr_wr_en && (csr_wr_addr == ADDR_TICLR);
  // Writes to TVAL are accepted on the bus but have no effect, so TVAL has no
  // write strobe of its own.

  // ---------------------------------------------------------------------------
  // Configuration fields and counter status
  // ---------------------------------------------------------------------------
  logic               cfg_en;
  logic               cfg_periodic;
  logic [TIMER_W-1:0] reload_val;     // reload from the current TCFG
  logic [TIMER_W-1:0] new_reload_val; // reload from the TCFG value being written
  logic               tval_zero;
  logic               tval_ones;
  logic               timeout;

  assign cfg_en         = tcfg_q[0];
  assign cfg_periodic   = tcfg_q[1];
  assign reload_val     = {tcfg_q[TIMER_W-1:2], 2'b00};
  assign new_reload_val = {csr_wr_data[TIMER_W-1:2], 2'b00};
  assign tval_zero      = (tval_q == '0);
  assign tval_ones      = (tval_q == CNT_ONES);

  // The timeout is judged on the state before the edge, so a TCFG write in
  // the same cycle cannot suppress it.
  assign timeout        = cfg_en && tval_zero;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    tid_d  = tid_q;
    tcfg_d = tcfg_q;
    tval_d = tval_q;
    ti_d   = ti_q;

    if (wr_tid) begin
      tid_d = csr_wr_data;
    end

    if (wr_tcfg) begin
      // Every TCFG write reloads the counter, even when it disables the timer.
      tcfg_d = csr_wr_data[TIMER_W-1:0];
      tval_d = new_reload_val;
    end else if (!cfg_en) begin
      tval_d = tval_q;
    end else if (tval_zero) begin
      // Periodic timers restart from the reload value; one-shot timers park at
      // all-ones, which the next branch then holds.
      tval_d = cfg_periodic ? reload_val : CNT_ONES;
    end else if (tval_ones && !cfg_periodic) begin
      tval_d = tval_q;
    end else begin
      tval_d = tval_q - CNT_ONE;
    end

    // Set has priority over clear so an acknowledge issued in the very cycle
    // of a new timeout cannot lose that timeout.
    if (timeout) begin
      ti_d = 1'b1;
    end else if (wr_ticlr && csr_wr_data[0]) begin
      ti_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      tid_q  <= TID_RESET;
      tcfg_q <= '0;
      tval_q <= '0;
      ti_q   <= 1'b0;
    end else begin
      tid_q  <= tid_d;
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
      ti_q   <= ti_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port: purely combinational, so a read that coincides with a write to
  // the same CSR returns the value from before the edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    csr_rd_data = '0;
    csr_rd_hit  = 1'b0;
    unique case (csr_rd_addr)
      ADDR_TID: begin
        csr_rd_hit  = 1'b1;
        csr_rd_data = tid_q;
      end
      ADDR_TCFG: begin
        csr_rd_hit                  = 1'b1;
        csr_rd_data[TIMER_W-1:0]    = tcfg_q;
      end
      ADDR_TVAL: begin
        csr_rd_hit                  = 1'b1;
        csr_rd_data[TIMER_W-1:0]    = tval_q;
      end
      ADDR_TICLR: begin
        // TICLR is write-only and always reads as zero.
        csr_rd_hit  = 1'b1;
      end
      default: begin
        csr_rd_hit  = 1'b0;
      end
    endcase
  end

  assign timer_int = ti_q;

endmodule
